// File: rtl/serial_parity_frame_checker.sv
// rtl/serial_parity_frame_checker.sv - serial even-parity frame checker with valid/ready result
// Optional saturating parity-error counter enabled by defining PFC_ERR_CNT_EN.
module serial_parity_frame_checker #(
    parameter int DATA_W = 4,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              bit_i,
    input  logic              bit_vld_i,
    output logic [DATA_W-1:0] data_o,
    output logic              cep_o,
    output logic              out_vld_o,
    input  logic              out_rdy_i,
    output logic              busy_o
`ifdef PFC_ERR_CNT_EN
    ,
    input  logic              err_clr_i,
    output logic [ERR_W-1:0]  err_cnt_o
`endif
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_clr;
    logic              shift_en;
    logic              par_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // start_i restarts a frame from any state except OUT, where it only
    // takes effect together with the output handshake.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = SHIFT;
                    cnt_clr   = 1'b1;
                end
            end
            SHIFT: begin
                if (start_i) begin
                    cnt_clr = 1'b1;
                end else if (bit_vld_i) begin
                    shift_en = 1'b1;
                    if (cnt == LAST_BIT) begin
                        state_nxt = PAR;
                    end
                end
            end
            PAR: begin
                if (start_i) begin
                    state_nxt = SHIFT;
                    cnt_clr   = 1'b1;
                end else if (bit_vld_i) begin
                    par_en    = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (out_rdy_i) begin
                    if (start_i) begin
                        state_nxt = SHIFT;
                        cnt_clr   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            data_o <= '0;
            cep_o  <= 1'b0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (shift_en) begin
                cnt         <= cnt + 1'b1;
                data_o[cnt] <= bit_i;
            end
            if (par_en) begin
                cep_o <= (^data_o) ^ bit_i;
            end
        end
    end

    assign out_vld_o = (state == OUT);
    assign busy_o    = (state == SHIFT) || (state == PAR);

`ifdef PFC_ERR_CNT_EN
    // Clear wins over a coincident error handshake; the count saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_o <= '0;
        end else if (err_clr_i) begin
            err_cnt_o <= '0;
        end else if (out_vld_o && out_rdy_i && cep_o && (err_cnt_o != {ERR_W{1'b1}})) begin
            err_cnt_o <= err_cnt_o + 1'b1;
        end
    end
`endif

endmodule
